// File: rtl/test_engine_pkg.sv
// Shared definitions for the test engine and its inverse: word geometry,
// FSM state encoding, and the clog2/swap32 helpers.
package test_engine_pkg;

  localparam int WORD_WIDTH = 64;
  localparam int HALF_WIDTH = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] swap32(input logic [WORD_WIDTH-1:0] x);
    return {x[HALF_WIDTH-1:0], x[WORD_WIDTH-1:HALF_WIDTH]};
  endfunction

endpackage

// File: rtl/test_engine_inv_round.sv
// One combinational inverse round: undoes A' = A ^ swap32(B), B' = A.
module test_engine_inv_round
  import test_engine_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] c,
  input  logic [WORD_WIDTH-1:0] d,
  output logic [WORD_WIDTH-1:0] c_next,
  output logic [WORD_WIDTH-1:0] d_next
);

  assign c_next = d;
  assign d_next = swap32(c ^ d);

endmodule

// File: rtl/test_engine_inverse.sv
// Iterative inverse of the test engine: ROUNDS inverse rounds, one per cycle.
// Optional expected-value compare enabled by TEST_ENGINE_INVERSE_CHECK_EN.
module test_engine_inverse
  import test_engine_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_din,
  output logic                  in_ready_dout,
  input  logic [WORD_WIDTH-1:0] wordC_din,
  input  logic [WORD_WIDTH-1:0] wordD_din,
`ifdef TEST_ENGINE_INVERSE_CHECK_EN
  input  logic [WORD_WIDTH-1:0] expA_din,
  input  logic [WORD_WIDTH-1:0] expB_din,
  output logic                  match_dout,
`endif
  output logic                  out_valid_dout,
  input  logic                  out_ready_din,
  output logic                  busy_dout,
  output logic [WORD_WIDTH-1:0] wordA_dout,
  output logic [WORD_WIDTH-1:0] wordB_dout
);

  localparam int CNT_W = clog2(ROUNDS + 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [WORD_WIDTH-1:0] c_reg;
  logic [WORD_WIDTH-1:0] d_reg;
  logic [WORD_WIDTH-1:0] c_nxt;
  logic [WORD_WIDTH-1:0] d_nxt;

  test_engine_inv_round u_round (
    .c      (c_reg),
    .d      (d_reg),
    .c_next (c_nxt),
    .d_next (d_nxt)
  );

`ifdef TEST_ENGINE_INVERSE_CHECK_EN
  logic [WORD_WIDTH-1:0] exp_a;
  logic [WORD_WIDTH-1:0] exp_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_a <= '0;
      exp_b <= '0;
    end else if (state == IDLE && in_valid_din) begin
      exp_a <= expA_din;
      exp_b <= expB_din;
    end
  end

  assign match_dout = (state == HOLD) && (c_reg == exp_a) && (d_reg == exp_b);
`endif

  // The last round is the one taken with cnt == 1; data then freezes in HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      c_reg <= '0;
      d_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_din) begin
            c_reg <= wordC_din;
            d_reg <= wordD_din;
            cnt   <= CNT_W'(ROUNDS);
            state <= RUN;
          end
        end
        RUN: begin
          c_reg <= c_nxt;
          d_reg <= d_nxt;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= HOLD;
        end
        HOLD: begin
          if (out_ready_din) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready_dout  = (state == IDLE);
  assign out_valid_dout = (state == HOLD);
  assign busy_dout      = (state != IDLE);
  assign wordA_dout     = c_reg;
  assign wordB_dout     = d_reg;

endmodule
